// File: rtl/if_stage_bp.sv
// Fetch stage: holds the fetch PC, drives the instruction RAM and predicts the next PC.
// Optional dynamic prediction (BTB + 2-bit counters) is built when IF_BTB_DYNAMIC_PRED_EN is defined.
`timescale 1ns/1ps
module if_stage_bp #(
    parameter logic [31:0] RESET_PC    = 32'h1c000000,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic        inst_ram_en,
    output logic [31:0] inst_ram_addr,
    output logic [3:0]  inst_ram_w_en,
    output logic [31:0] inst_ram_w_data,
    input  logic        ipd_allow_in,
    output logic        if_to_ipd_valid,
    output logic [31:0] if_to_ipd_pc,
    output logic        if_to_ipd_pred_taken,
    output logic [31:0] if_to_ipd_pred_pc
);
    logic [31:0] r_pc;
    logic        r_if_valid;
    logic        r_pend_valid;
    logic [31:0] r_pend_pc;

    logic        w_allow_in;
    logic [31:0] w_seq_pc;
    logic        w_pred_taken;
    logic [31:0] w_pred_pc;
    logic [31:0] w_next_pc;

    assign w_seq_pc = r_pc + 32'd4;

`ifdef IF_BTB_DYNAMIC_PRED_EN
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic [BTB_ENTRIES-1:0] r_btb_valid;
    logic [TAG_W-1:0]       r_btb_tag    [BTB_ENTRIES];
    logic [31:0]            r_btb_target [BTB_ENTRIES];
    logic [1:0]             r_btb_ctr    [BTB_ENTRIES];

    // Resolved-branch updates are registered and written one cycle later.
    logic        r_upd_valid;
    logic [29:0] r_upd_pc;
    logic        r_upd_taken;
    logic [31:0] r_upd_target;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_upd_hit;
    logic [1:0]       w_cur_ctr;
    logic [1:0]       w_new_ctr;
    logic             w_unused_lsb;

    assign w_unused_lsb = ^upd_pc[1:0];

    assign w_idx        = r_pc[IDX_W+1:2];
    assign w_tag        = r_pc[31:IDX_W+2];
    assign w_hit        = r_btb_valid[w_idx] && (r_btb_tag[w_idx] == w_tag);
    assign w_pred_taken = ~reset & w_hit & r_btb_ctr[w_idx][1];
    assign w_pred_pc    = w_pred_taken ? r_btb_target[w_idx] : w_seq_pc;

    assign w_upd_idx = r_upd_pc[IDX_W-1:0];
    assign w_upd_tag = r_upd_pc[29:IDX_W];
    assign w_upd_hit = r_btb_valid[w_upd_idx] && (r_btb_tag[w_upd_idx] == w_upd_tag);
    assign w_cur_ctr = r_btb_ctr[w_upd_idx];

    always_comb begin
        w_new_ctr = w_cur_ctr;
        if (r_upd_taken && (w_cur_ctr != 2'b11))
            w_new_ctr = w_cur_ctr + 2'b01;
        else if (!r_upd_taken && (w_cur_ctr != 2'b00))
            w_new_ctr = w_cur_ctr - 2'b01;
    end

    always_ff @(posedge clk) begin
        r_upd_pc     <= upd_pc[31:2];
        r_upd_taken  <= upd_taken;
        r_upd_target <= upd_target;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_btb_valid <= '0;
            r_upd_valid <= 1'b0;
        end else begin
            r_upd_valid <= upd_valid;
            if (r_upd_valid) begin
                if (w_upd_hit) begin
                    r_btb_ctr[w_upd_idx] <= w_new_ctr;
                    if (r_upd_taken)
                        r_btb_target[w_upd_idx] <= r_upd_target;
                end else if (r_upd_taken) begin
                    // Miss on a taken branch evicts whatever occupies the slot.
                    r_btb_valid[w_upd_idx]  <= 1'b1;
                    r_btb_tag[w_upd_idx]    <= w_upd_tag;
                    r_btb_target[w_upd_idx] <= r_upd_target;
                    r_btb_ctr[w_upd_idx]    <= 2'b10;
                end
            end
        end
    end
`else
    logic [BTB_ENTRIES-1:0] w_unused_cfg;
    logic                   w_unused_upd;

    assign w_unused_cfg = '0;
    assign w_unused_upd = ^{upd_valid, upd_pc, upd_taken, upd_target};

    assign w_pred_taken = 1'b0;
    assign w_pred_pc    = w_seq_pc;
`endif

    assign w_allow_in = ~r_if_valid | ipd_allow_in;

    always_comb begin
        w_next_pc = w_pred_pc;
        if (redirect_valid)
            w_next_pc = redirect_pc;
        else if (r_pend_valid)
            w_next_pc = r_pend_pc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_PC - 32'd4;
            r_if_valid   <= 1'b0;
            r_pend_valid <= 1'b0;
        end else if (w_allow_in) begin
            r_pc         <= w_next_pc;
            r_if_valid   <= 1'b1;
            r_pend_valid <= 1'b0;
        end else if (redirect_valid) begin
            // Stalled redirect: flush IF and park the target until the fetch can go.
            r_pend_valid <= 1'b1;
            r_if_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !w_allow_in && redirect_valid)
            r_pend_pc <= redirect_pc;
    end

    assign inst_ram_en          = 1'b1;
    assign inst_ram_w_en        = 4'b0000;
    assign inst_ram_w_data      = 32'd0;
    assign inst_ram_addr        = w_allow_in ? w_next_pc : r_pc;

    assign if_to_ipd_valid      = r_if_valid;
    assign if_to_ipd_pc         = r_pc;
    assign if_to_ipd_pred_taken = w_pred_taken;
    assign if_to_ipd_pred_pc    = w_pred_pc;
endmodule
